// File: rtl/mem.sv
// mem: memory-access pipeline stage; registers execute results, runs one
// data-memory load/store per instruction over req/ack, and formats load data.
package mem_pkg;
    localparam int ADDR_W     = 32;
    localparam int INSTR_W    = 32;
    localparam int WORD_W     = 32;
    localparam int REG_IDX_W  = 5;
    localparam int DEST_SRC_W = 2;
    localparam int MEM_OP_W   = 4;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = '0;
    localparam logic [MEM_OP_W-1:0] OP_NONE = 4'h0, OP_LB = 4'h1, OP_LH = 4'h2, OP_LW = 4'h3,
                                    OP_LBU = 4'h4, OP_LHU = 4'h5, OP_SB = 4'h9, OP_SH = 4'hA,
                                    OP_SW = 4'hB;
endpackage

module mem
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  stall,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic [WORD_W-1:0]     i_alu_eval,
    input  logic [WORD_W-1:0]     i_store_data,
    input  logic [MEM_OP_W-1:0]   i_mem_op,
    input  logic [DEST_SRC_W-1:0] i_dest_src,
    input  logic [REG_IDX_W-1:0]  i_dest_reg,
    output logic [ADDR_W-1:0]     o_pc,
    output logic [INSTR_W-1:0]    o_instr,
    output logic [DEST_SRC_W-1:0] o_dest_src,
    output logic [REG_IDX_W-1:0]  o_dest_reg,
    output logic [WORD_W-1:0]     o_result,
    output logic                  o_busy,
    output logic                  o_misaligned,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_W-1:0]     o_dmem_addr,
    output logic [WORD_W-1:0]     o_dmem_wdata,
    output logic [3:0]            o_dmem_be,
    input  logic                  i_dmem_ack,
    input  logic [WORD_W-1:0]     i_dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       r_pc;
    logic [INSTR_W-1:0]      r_instr;
    logic [WORD_W-1:0]       r_alu_eval;
    logic [WORD_W-1:0]       r_store_data;
    logic [MEM_OP_W-1:0]     r_mem_op;
    logic [DEST_SRC_W-1:0]   r_dest_src;
    logic [REG_IDX_W-1:0]    r_dest_reg;
    logic [WORD_W-1:0]       r_rdata;

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_half(input logic [MEM_OP_W-1:0] op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic is_word(input logic [MEM_OP_W-1:0] op);
        return op inside {OP_LW, OP_SW};
    endfunction

    function automatic logic aligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] a);
        return is_half(op) ? !a[0] : is_word(op) ? (a == 2'b00) : 1'b1;
    endfunction

    // The input register freezes during REQ so the bus signals stay stable.
    logic capture;
    assign capture = !stall && state != REQ;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= IDLE;
            r_pc         <= '0;
            r_instr      <= '0;
            r_alu_eval   <= '0;
            r_store_data <= '0;
            r_mem_op     <= OP_NONE;
            r_dest_src   <= DEST_SRC_NONE;
            r_dest_reg   <= '0;
            r_rdata      <= '0;
        end else if (capture) begin
            r_pc         <= i_pc;
            r_instr      <= i_instr;
            r_alu_eval   <= i_alu_eval;
            r_store_data <= i_store_data;
            r_mem_op     <= i_mem_op;
            r_dest_src   <= i_dest_src;
            r_dest_reg   <= i_dest_reg;
            state        <= ((is_load(i_mem_op) || is_store(i_mem_op)) &&
                             aligned(i_mem_op, i_alu_eval[1:0])) ? REQ : IDLE;
        end else if (state == REQ && i_dmem_ack) begin
            state <= DONE;
            if (is_load(r_mem_op))
                r_rdata <= i_dmem_rdata;
        end
    end

    logic [1:0]        a;
    logic [WORD_W-1:0] shifted;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] ld_val;

    assign a       = r_alu_eval[1:0];
    assign shifted = r_rdata >> {a, 3'b000};
    assign b       = shifted[7:0];
    assign h       = a[1] ? r_rdata[31:16] : r_rdata[15:0];
    assign ld_val  = (r_mem_op == OP_LB)  ? {{24{b[7]}}, b} :
                     (r_mem_op == OP_LBU) ? {24'b0, b} :
                     (r_mem_op == OP_LH)  ? {{16{h[15]}}, h} :
                     (r_mem_op == OP_LHU) ? {16'b0, h} : r_rdata;

    assign o_pc         = r_pc;
    assign o_instr      = r_instr;
    assign o_dest_reg   = r_dest_reg;
    assign o_misaligned = (is_load(r_mem_op) || is_store(r_mem_op)) && !aligned(r_mem_op, a);
    assign o_dest_src   = o_misaligned ? DEST_SRC_NONE : r_dest_src;
    assign o_result     = (state == DONE && is_load(r_mem_op)) ? ld_val : r_alu_eval;
    assign o_busy       = state == REQ;
    assign o_dmem_req   = state == REQ;
    assign o_dmem_we    = is_store(r_mem_op);
    assign o_dmem_addr  = {r_alu_eval[ADDR_W-1:2], 2'b00};
    assign o_dmem_wdata = (r_mem_op == OP_SB) ? {4{r_store_data[7:0]}} :
                          (r_mem_op == OP_SH) ? {2{r_store_data[15:0]}} : r_store_data;
    assign o_dmem_be    = (r_mem_op inside {OP_LB, OP_LBU, OP_SB}) ? 4'b0001 << a :
                          is_half(r_mem_op) ? (a[1] ? 4'b1100 : 4'b0011) :
                          is_word(r_mem_op) ? 4'b1111 : 4'b0000;
endmodule

// File: tb/tb_mem.sv
// tb_mem: directed checks of the mem stage handshake, formatting and reset.
module tb_mem;
    import mem_pkg::*;

    logic                  clk = 0;
    logic                  clr_n = 0;
    logic                  stall = 0;
    logic [ADDR_W-1:0]     i_pc = '0;
    logic [INSTR_W-1:0]    i_instr = '0;
    logic [WORD_W-1:0]     i_alu_eval = '0;
    logic [WORD_W-1:0]     i_store_data = '0;
    logic [MEM_OP_W-1:0]   i_mem_op = OP_NONE;
    logic [DEST_SRC_W-1:0] i_dest_src = '0;
    logic [REG_IDX_W-1:0]  i_dest_reg = '0;
    logic [ADDR_W-1:0]     o_pc;
    logic [INSTR_W-1:0]    o_instr;
    logic [DEST_SRC_W-1:0] o_dest_src;
    logic [REG_IDX_W-1:0]  o_dest_reg;
    logic [WORD_W-1:0]     o_result;
    logic                  o_busy, o_misaligned, o_dmem_req, o_dmem_we;
    logic [ADDR_W-1:0]     o_dmem_addr;
    logic [WORD_W-1:0]     o_dmem_wdata;
    logic [3:0]            o_dmem_be;
    logic                  i_dmem_ack = 0;
    logic [WORD_W-1:0]     i_dmem_rdata = '0;

    int total = 0;
    int bad = 0;

    mem dut (
        .clk(clk), .clr_n(clr_n), .stall(stall),
        .i_pc(i_pc), .i_instr(i_instr), .i_alu_eval(i_alu_eval),
        .i_store_data(i_store_data), .i_mem_op(i_mem_op),
        .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
        .o_pc(o_pc), .o_instr(o_instr), .o_dest_src(o_dest_src),
        .o_dest_reg(o_dest_reg), .o_result(o_result), .o_busy(o_busy),
        .o_misaligned(o_misaligned), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pc, input logic [1:0] ds, input logic [4:0] dr);
        i_mem_op     = op;
        i_alu_eval   = alu;
        i_store_data = sd;
        i_pc         = pc;
        i_instr      = 32'h0000_0013 + pc;
        i_dest_src   = ds;
        i_dest_reg   = dr;
    endtask

    task automatic test_reset();
        clr_n = 0;
        issue(OP_LW, 32'h104, 32'h1, 32'h10, 2'd3, 5'd9);
        repeat (2) @(negedge clk);
        total++;
        if ({o_dmem_req, o_busy, o_misaligned} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=000", {o_dmem_req, o_busy, o_misaligned});
        end
        total++;
        if ({o_pc, o_result, o_dest_src, o_dest_reg} !== '0) begin
            bad++; $display("FAIL reset_regs pc=%h result=%h ds=%h dr=%h exp=0", o_pc, o_result, o_dest_src, o_dest_reg);
        end
        issue(OP_NONE, 0, 0, 0, 0, 0);
        clr_n = 1;
    endtask

    task automatic test_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] expv);
        @(negedge clk);
        issue(op, addr, 32'h0, 32'h300, 2'd1, 5'd3);
        @(negedge clk);
        total++;
        if ({o_dmem_req, o_busy, o_dmem_we} !== 3'b110) begin
            bad++; $display("FAIL %s req_busy_we got=%b exp=110", tag, {o_dmem_req, o_busy, o_dmem_we});
        end
        total++;
        if (o_dmem_addr !== {addr[31:2], 2'b00}) begin
            bad++; $display("FAIL %s addr got=%h exp=%h", tag, o_dmem_addr, {addr[31:2], 2'b00});
        end
        i_dmem_ack = 1;
        i_dmem_rdata = rdata;
        issue(OP_NONE, 32'h5, 32'h0, 32'h304, 2'd1, 5'd1);
        @(negedge clk);
        i_dmem_ack = 0;
        i_dmem_rdata = 32'h0;
        total++;
        if ({o_dmem_req, o_busy} !== 2'b00) begin
            bad++; $display("FAIL %s done_req_busy got=%b exp=00", tag, {o_dmem_req, o_busy});
        end
        total++;
        if (o_result !== expv || o_pc !== 32'h300) begin
            bad++; $display("FAIL %s result got=%h pc=%h exp=%h pc=300", tag, o_result, o_pc, expv);
        end
        stall = 1;
        repeat (2) @(negedge clk);
        total++;
        if (o_result !== expv) begin
            bad++; $display("FAIL %s stall_hold got=%h exp=%h", tag, o_result, expv);
        end
        stall = 0;
        @(negedge clk);
        total++;
        if (o_result !== 32'h5 || o_pc !== 32'h304) begin
            bad++; $display("FAIL %s next_capture result=%h pc=%h exp=5 pc=304", tag, o_result, o_pc);
        end
    endtask

    task automatic test_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] d, input int waits,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be);
        @(negedge clk);
        issue(op, addr, d, 32'h400, 2'd0, 5'd0);
        @(negedge clk);
        issue(OP_NONE, 32'h66, 32'h0, 32'h999, 2'd1, 5'd2);
        for (int i = 0; i <= waits; i++) begin
            total++;
            if ({o_dmem_req, o_busy, o_dmem_we} !== 3'b111 || o_dmem_wdata !== exp_wdata ||
                o_dmem_be !== exp_be || o_dmem_addr !== {addr[31:2], 2'b00} || o_pc !== 32'h400) begin
                bad++;
                $display("FAIL %s req_cycle%0d ctl=%b wdata=%h be=%b addr=%h pc=%h exp=111 %h %b %h 400",
                         tag, i, {o_dmem_req, o_busy, o_dmem_we}, o_dmem_wdata, o_dmem_be, o_dmem_addr,
                         o_pc, exp_wdata, exp_be, {addr[31:2], 2'b00});
            end
            if (i == waits) i_dmem_ack = 1;
            @(negedge clk);
        end
        i_dmem_ack = 0;
        total++;
        if ({o_dmem_req, o_busy} !== 2'b00 || o_result !== addr || o_pc !== 32'h400) begin
            bad++; $display("FAIL %s done req_busy=%b result=%h pc=%h exp=00 %h 400",
                            tag, {o_dmem_req, o_busy}, o_result, o_pc, addr);
        end
        @(negedge clk);
        total++;
        if (o_pc !== 32'h999 || o_result !== 32'h66) begin
            bad++; $display("FAIL %s next_capture pc=%h result=%h exp=999 66", tag, o_pc, o_result);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        issue(OP_LW, 32'h101, 32'h0, 32'h500, 2'd2, 5'd4);
        @(negedge clk);
        total++;
        if ({o_dmem_req, o_busy, o_misaligned} !== 3'b001 || o_dest_src !== DEST_SRC_NONE) begin
            bad++; $display("FAIL misaligned req_busy_mis=%b ds=%h exp=001 ds=0",
                            {o_dmem_req, o_busy, o_misaligned}, o_dest_src);
        end
        issue(OP_NONE, 32'h77, 32'h0, 32'h504, 2'd2, 5'd4);
        @(negedge clk);
        total++;
        if (o_pc !== 32'h504 || o_misaligned !== 1'b0 || o_dest_src !== 2'd2 || o_result !== 32'h77) begin
            bad++; $display("FAIL misaligned_next pc=%h mis=%b ds=%h result=%h exp=504 0 2 77",
                            o_pc, o_misaligned, o_dest_src, o_result);
        end
    endtask

    task automatic test_nonmem();
        @(negedge clk);
        issue(OP_NONE, 32'h55, 32'h0, 32'h600, 2'd3, 5'd7);
        @(negedge clk);
        total++;
        if (o_result !== 32'h55 || o_dmem_req !== 1'b0 || o_dest_src !== 2'd3 || o_dest_reg !== 5'd7) begin
            bad++; $display("FAIL nonmem result=%h req=%b ds=%h dr=%h exp=55 0 3 7",
                            o_result, o_dmem_req, o_dest_src, o_dest_reg);
        end
        stall = 1;
        issue(OP_LW, 32'hAA, 32'h0, 32'h604, 2'd1, 5'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (o_result !== 32'h55 || o_pc !== 32'h600 || o_dest_reg !== 5'd7 || o_dmem_req !== 1'b0) begin
                bad++; $display("FAIL nonmem_stall%0d result=%h pc=%h dr=%h req=%b exp=55 600 7 0",
                                i, o_result, o_pc, o_dest_reg, o_dmem_req);
            end
        end
        issue(OP_NONE, 32'hAA, 32'h0, 32'h604, 2'd1, 5'd1);
        stall = 0;
        @(negedge clk);
        total++;
        if (o_result !== 32'hAA || o_pc !== 32'h604) begin
            bad++; $display("FAIL nonmem_release result=%h pc=%h exp=AA 604", o_result, o_pc);
        end
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        issue(OP_LW, 32'h200, 32'h0, 32'h700, 2'd1, 5'd9);
        @(negedge clk);
        total++;
        if (o_dmem_req !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pre req got=%b exp=1", o_dmem_req);
        end
        issue(OP_NONE, 0, 0, 0, 0, 0);
        #2 clr_n = 0;
        #1;
        total++;
        if ({o_dmem_req, o_busy} !== 2'b00 || o_pc !== '0 || o_result !== '0 || o_dest_reg !== '0) begin
            bad++; $display("FAIL rst_mid_async req_busy=%b pc=%h result=%h dr=%h exp=00 0 0 0",
                            {o_dmem_req, o_busy}, o_pc, o_result, o_dest_reg);
        end
        @(negedge clk);
        clr_n = 1;
        stall = 1;
        @(negedge clk);
        i_dmem_ack = 1;
        i_dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        i_dmem_ack = 0;
        total++;
        if ({o_dmem_req, o_busy} !== 2'b00 || o_result !== '0) begin
            bad++; $display("FAIL rst_mid_late_ack req_busy=%b result=%h exp=00 0", {o_dmem_req, o_busy}, o_result);
        end
        stall = 0;
    endtask

    initial begin
        test_reset();
        test_load("lw", OP_LW, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        test_load("lb", OP_LB, 32'h103, 32'h80FFFF7F, 32'hFFFFFF80);
        test_load("lbu", OP_LBU, 32'h103, 32'h80FFFF7F, 32'h00000080);
        test_load("lh", OP_LH, 32'h102, 32'h80011234, 32'hFFFF8001);
        test_load("lhu", OP_LHU, 32'h100, 32'hFFFF8765, 32'h00008765);
        test_store("sh", OP_SH, 32'h102, 32'h1234ABCD, 3, 32'hABCDABCD, 4'b1100);
        test_store("sb", OP_SB, 32'h101, 32'h0000005A, 0, 32'h5A5A5A5A, 4'b0010);
        test_store("sw", OP_SW, 32'h108, 32'hCAFEF00D, 1, 32'hCAFEF00D, 4'b1111);
        test_misaligned();
        test_nonmem();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
